sub_serial: RTL and testbench
=============================

SUB_SERIAL -- requirements
Module: sub_serial

Interface
REQ-001 Parameter N, default 1024, total operand width in bits.
REQ-002 Parameter CC, default 512, clock cycles per operation; W = N/CC (default 2) digit width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin an operation; sampled only in IDLE.
REQ-006 a  input  W  minuend digit, LSB-first, digit k presented in RUN cycle k.
REQ-007 b  input  W  subtrahend digit, same timing as a.
REQ-008 c  output  W  difference digit, combinational, valid when valid_out=1.
REQ-009 valid_out  output  1  high in every RUN cycle.
REQ-010 busy  output  1  high in RUN and DONE.
REQ-011 done  output  1  one-cycle pulse after the last digit.
REQ-012 borrow_out  output  1  final borrow (1 = a<b as unsigned N-bit), valid while done=1.

Function
REQ-013 FSM states IDLE, RUN, DONE; IDLE --start--> RUN; RUN --count==CC-1--> DONE; DONE --> IDLE unconditionally.
REQ-014 On the IDLE->RUN transition, borrow register and digit counter are loaded with 0.
REQ-015 In RUN: c = (a - b - borrow) mod 2^W; borrow_next = 1 iff a < b + borrow (unsigned, W+1-bit compare).
REQ-016 Borrow register updates to borrow_next and counter increments on every RUN cycle; zero latency from a/b to c.
REQ-017 Counter is ceil(log2(CC)) bits, counts 0..CC-1, no wrap past CC-1.
REQ-018 On the last RUN cycle (count==CC-1), borrow_next is captured into borrow_out register.
REQ-019 DONE lasts exactly one cycle: done=1, valid_out=0, borrow_out held.
REQ-020 start asserted in RUN or DONE is ignored; start in the DONE-following IDLE cycle begins a new operation.
REQ-021 Outside RUN, c = 0 and valid_out = 0; a/b are don't-care.
REQ-022 borrow_out holds its value through IDLE until the next RUN->DONE capture.
REQ-023 CC=1 is legal: RUN lasts one cycle, then DONE.

Reset
REQ-024 rst=1 forces IDLE, counter=0, borrow=0, borrow_out=0, done=0, busy=0, valid_out=0, c=0 immediately, independent of clk.
REQ-025 rst asserted mid-RUN aborts the operation; no done pulse is produced; first post-reset cycle is IDLE.

Structure
REQ-026 Package sub_serial_pkg holds default N, CC, derived W, counter-width function and the state enum.
REQ-027 One sub-module sub_digit (W-bit a, b, borrow_in -> W-bit diff, borrow_out, purely combinational) is instantiated once.
REQ-028 All flops reset asynchronously; no other clocks or latches.

Verification
REQ-029 N=1024,CC=512; a=all ones, b=0, start -> c=3 for 512 cycles, done at cycle 513, borrow_out=0.
REQ-030 a=0, b=1 (digit0 b=1, rest 0) -> c digit0=3, digits1..511=3 (borrow ripples), borrow_out=1.
REQ-031 a=b=random equal operands -> every c=0, borrow_out=0; a=5, b=3 (N=1024) -> digit0 c=2, rest 0, borrow_out=0.
REQ-032 start pulsed at RUN cycles 10 and 300 and in DONE -> no restart, exactly one done pulse, counter unaffected.
REQ-033 rst asserted at RUN cycle 200, released 3 cycles later -> all outputs 0 during reset, no done, new start gives correct result for a=7,b=9 (borrow_out=1).
REQ-034 Back-to-back: start held high continuously -> operations repeat with one DONE and one IDLE cycle between RUN phases.

Source files
------------

// File: rtl/sub_serial_pkg.sv
// -----------------------------------------------------------------------------
// sub_serial_pkg
// Shared definitions for the digit-serial subtractor:
//   - default operand width and cycles per operation, plus the derived
//     digit width
//   - cnt_width(): width of the digit counter for a given cycle count
//   - state_t: control FSM state encoding
// -----------------------------------------------------------------------------
package sub_serial_pkg;

  localparam int N_DEFAULT  = 1024;
  localparam int CC_DEFAULT = 512;
  localparam int W_DEFAULT  = N_DEFAULT / CC_DEFAULT;

  // ceil(log2(cc)), but never less than one bit so that CC=1 still gets a
  // real (constant-zero) counter register.
  function automatic int cnt_width(input int cc);
    int w;
    w = 1;
    while ((1 << w) < cc) begin
      w = w + 1;
    end
    return w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : sub_serial_pkg

// File: rtl/sub_serial_digit.sv
// -----------------------------------------------------------------------------
// sub_digit
// Purely combinational W-bit subtract-with-borrow cell.
//   i_a, i_b   : W-bit minuend / subtrahend digits
//   i_borrow   : incoming borrow (from the previous, less significant digit)
//   o_diff     : (i_a - i_b - i_borrow) mod 2^W
//   o_borrow   : 1 when i_a < i_b + i_borrow (unsigned)
// -----------------------------------------------------------------------------
module sub_digit #(
  parameter int W = 2
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_borrow,
  output logic [W-1:0] o_diff,
  output logic         o_borrow
);

  // One extra bit of headroom: the top bit of the W+1-bit difference is set
  // exactly when the result went negative, i.e. when a borrow is needed.
  logic [W:0] w_full;

  assign w_full   = {1'b0, i_a} - {1'b0, i_b} - {{W{1'b0}}, i_borrow};
  assign o_diff   = w_full[W-1:0];
  assign o_borrow = w_full[W];

endmodule : sub_digit

// File: rtl/sub_serial.sv
// -----------------------------------------------------------------------------
// sub_serial
// Digit-serial N-bit unsigned subtractor, W = N/CC bits per clock, LSB first.
//   clk, rst    : clock (rising edge) and asynchronous active-high reset
//   start       : begins an operation; only looked at in IDLE
//   a, b        : minuend / subtrahend digit k, presented in RUN cycle k
//   c           : difference digit, combinational from a/b, valid in RUN
//   valid_out   : high in every RUN cycle
//   busy        : high in RUN and DONE
//   done        : one-cycle pulse after the last digit
//   borrow_out  : final borrow (a < b over all N bits); captured on the last
//                 RUN cycle and held until the next capture
// -----------------------------------------------------------------------------
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int  N  = N_DEFAULT,
  parameter int  CC = CC_DEFAULT,
  localparam int W  = N / CC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic         valid_out,
  output logic         busy,
  output logic         done,
  output logic         borrow_out
);

  localparam int             CW   = cnt_width(CC);
  localparam logic [CW-1:0]  LAST = CW'(CC - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic          r_borrow;
  logic          r_borrow_out;

  logic [W-1:0]  w_diff;
  logic          w_borrow_next;
  logic          w_last;

  assign w_last = (r_cnt == LAST);

  sub_digit #(
    .W (W)
  ) u_digit (
    .i_a      (a),
    .i_b      (b),
    .i_borrow (r_borrow),
    .o_diff   (w_diff),
    .o_borrow (w_borrow_next)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking (<=) assignments so that all
  // flops sample their inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE:             w_state_next = ST_IDLE;
      default:             w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (Moore flags, c passed through only while running)
  // ---------------------------------------------------------------------------
  always_comb begin
    c         = '0;
    valid_out = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      ST_RUN: begin
        c         = w_diff;
        valid_out = 1'b1;
        busy      = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: digit counter, running borrow, captured final borrow
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_borrow     <= 1'b0;
      r_borrow_out <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt    <= '0;
            r_borrow <= 1'b0;
          end
        end
        ST_RUN: begin
          r_borrow <= w_borrow_next;
          if (w_last) begin
            // Counter parks on CC-1 rather than wrapping; it is reloaded on
            // the next start anyway.
            r_borrow_out <= w_borrow_next;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign borrow_out = r_borrow_out;

endmodule : sub_serial

// File: tb/tb_sub_serial.sv
// -----------------------------------------------------------------------------
// tb_sub_serial
// Directed self-checking bench for sub_serial at N=1024, CC=512 (W=2).
// Expected digits come from a full-width N+1-bit subtraction done in the bench.
// -----------------------------------------------------------------------------
module tb_sub_serial;

  localparam int N  = 1024;
  localparam int CC = 512;
  localparam int W  = 2;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic         valid_out;
  logic         busy;
  logic         done;
  logic         borrow_out;

  int n_checks = 0;
  int n_errors = 0;

  sub_serial #(
    .N  (N),
    .CC (CC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .c          (c),
    .valid_out  (valid_out),
    .busy       (busy),
    .done       (done),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {valid_out, busy, done, c, borrow_out}
  function automatic logic [W+3:0] all_outs();
    return {valid_out, busy, done, c, borrow_out};
  endfunction

  // Checks that the DUT is quietly idle with the given held borrow_out.
  task automatic expect_idle(input string tag, input logic exp_borrow);
    logic [W+3:0] got, exp;
    got = all_outs();
    exp = {3'b000, {W{1'b0}}, exp_borrow};
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: {valid,busy,done,c,borrow_out} got %b expected %b", tag, got, exp);
    end
  endtask

  // Runs one full operation starting in an IDLE cycle (just after a rising
  // edge) and returns in the IDLE cycle following DONE.
  //   hold : keep start high throughout (back-to-back operation)
  //   p1/p2: RUN cycles in which to pulse start (-1 for none)
  //   pdone: pulse start during DONE
  task automatic run_op(input string tag, input logic [N-1:0] ea, input logic [N-1:0] eb,
                        input bit hold, input int p1, input int p2, input bit pdone);
    logic [N:0]   diff;
    logic [W+2:0] got, exp;
    diff = {1'b0, ea} - {1'b0, eb};

    start = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({valid_out, busy, done} !== 3'b000) begin
      n_errors++;
      $display("FAIL %s idle_before_run: {valid,busy,done} got %b expected 000",
               tag, {valid_out, busy, done});
    end
    @(posedge clk);
    #1;
    start = hold;

    for (int k = 0; k < CC; k++) begin
      a = ea[k*W +: W];
      b = eb[k*W +: W];
      if (!hold) start = (k == p1) || (k == p2);
      @(negedge clk);
      got = {valid_out, busy, done, c};
      exp = {3'b110, diff[k*W +: W]};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL %s run_digit%0d: {valid,busy,done,c} got %b expected %b", tag, k, got, exp);
      end
      @(posedge clk);
      #1;
    end

    // DONE cycle: a/b are don't-care, drive junk to prove c ignores them.
    a = W'($urandom);
    b = W'($urandom);
    if (!hold) start = pdone;
    @(negedge clk);
    got = {valid_out, busy, done, c};
    exp = {3'b011, {W{1'b0}}};
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s done_cycle: {valid,busy,done,c} got %b expected %b", tag, got, exp);
    end
    n_checks++;
    if (borrow_out !== diff[N]) begin
      n_errors++;
      $display("FAIL %s borrow_out: got %b expected %b", tag, borrow_out, diff[N]);
    end
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    expect_idle("reset_immediate", 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    expect_idle("reset_released", 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_all_ones();
    run_op("all_ones", '1, '0, 1'b0, -1, -1, 1'b0);
    @(negedge clk);
    expect_idle("all_ones_after", 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_borrow_ripple();
    logic [N-1:0] one;
    one = '0;
    one[0] = 1'b1;
    run_op("ripple", '0, one, 1'b0, -1, -1, 1'b0);
    // borrow_out must stay held through IDLE.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_idle("ripple_hold", 1'b1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] v7, v9;
    logic [W+3:0] got;
    v7 = N'(7);
    v9 = N'(9);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      #1;
    end
    // Now in RUN cycle 200.
    n_checks++;
    if (valid_out !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_pre: valid_out got %b expected 1", valid_out);
    end
    rst = 1'b1;
    #1;
    expect_idle("rst_mid_immediate", 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_idle("rst_mid_held", 1'b0);
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    @(negedge clk);
    got = all_outs();
    n_checks++;
    if (got !== '0) begin
      n_errors++;
      $display("FAIL rst_mid_post_idle: outputs got %b expected 0", got);
    end
    @(posedge clk);
    #1;
    run_op("a7_b9", v7, v9, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_equal();
    logic [N-1:0] r;
    for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
    run_op("equal", r, r, 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_small();
    run_op("a5_b3", N'(5), N'(3), 1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_start_ignored();
    logic [N-1:0] va, vb;
    va = N'(32'h1234_5678);
    vb = N'(32'h8765_4321);
    // 0x12345678 < 0x87654321, so borrow_out ends at 1.
    run_op("start_ignored", va, vb, 1'b0, 10, 300, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_idle("start_ignored_no_restart", 1'b1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_first", N'(7), N'(9), 1'b1, -1, -1, 1'b0);
    run_op("b2b_second", N'(5), N'(3), 1'b1, -1, -1, 1'b0);
    start = 1'b0;
    @(negedge clk);
    expect_idle("b2b_final_idle", 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_borrow_ripple();
    test_reset_mid();
    test_equal();
    test_small();
    test_start_ignored();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sub_serial
